// File: rtl/lab3_cache_mem_arbiter_if.sv
// Memory-side stream bundle: request and response val/rdy channels with
// 4-byte memory message formats.
interface lab3_cache_mem_arbiter_if;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    logic         req_val;
    logic         req_rdy;
    mem_req_4B_t  req_msg;
    logic         resp_val;
    logic         resp_rdy;
    mem_resp_4B_t resp_msg;

    // master issues requests and consumes responses
    modport master (
        output req_val, req_msg, resp_rdy,
        input  req_rdy, resp_val, resp_msg
    );

    modport slave (
        input  req_val, req_msg, resp_rdy,
        output req_rdy, resp_val, resp_msg
    );

endinterface

// File: rtl/lab3_cache_mem_arbiter.sv
// Two-cache to one-memory arbiter: round-robin request merge plus an in-order
// source FIFO that steers memory responses back to the requesting cache.
module lab3_cache_mem_arbiter #(
    parameter int p_num_entries = 4
) (
    input logic                      clk,
    input logic                      reset,
    lab3_cache_mem_arbiter_if.slave  cache0,
    lab3_cache_mem_arbiter_if.slave  cache1,
    lab3_cache_mem_arbiter_if.master mem
);

    localparam int PW = $clog2(p_num_entries);
    localparam int CW = PW + 1;

    logic                     prio;
    logic [PW-1:0]            wr_ptr;
    logic [PW-1:0]            rd_ptr;
    logic [CW-1:0]            count;
    logic [p_num_entries-1:0] src_fifo;

    logic fifo_full;
    logic resp_active;
    logic head_id;
    logic grant_val;
    logic grant_id;
    logic push;
    logic pop;

    assign fifo_full = (count == CW'(p_num_entries));

    always_comb begin
        grant_val = 1'b0;
        grant_id  = 1'b0;
        if (!reset && !fifo_full) begin
            if (cache0.req_val && cache1.req_val) begin
                grant_val = 1'b1;
                grant_id  = prio;
            end else if (cache0.req_val) begin
                grant_val = 1'b1;
                grant_id  = 1'b0;
            end else if (cache1.req_val) begin
                grant_val = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign mem.req_val    = grant_val;
    assign mem.req_msg    = grant_id ? cache1.req_msg : cache0.req_msg;
    assign cache0.req_rdy = grant_val && !grant_id && mem.req_rdy;
    assign cache1.req_rdy = grant_val &&  grant_id && mem.req_rdy;

    // Responses only route while an id is outstanding; stray memory responses are not accepted.
    assign resp_active     = !reset && (count != '0);
    assign head_id         = src_fifo[rd_ptr];
    assign cache0.resp_val = resp_active && !head_id && mem.resp_val;
    assign cache1.resp_val = resp_active &&  head_id && mem.resp_val;
    assign cache0.resp_msg = mem.resp_msg;
    assign cache1.resp_msg = mem.resp_msg;
    assign mem.resp_rdy    = resp_active && (head_id ? cache1.resp_rdy : cache0.resp_rdy);

    assign push = grant_val && mem.req_rdy;
    assign pop  = mem.resp_val && mem.resp_rdy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            src_fifo <= '0;
        end else begin
            if (push) begin
                prio             <= ~grant_id;
                src_fifo[wr_ptr] <= grant_id;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_cache_mem_arbiter.sv
// Directed bench for the cache/memory arbiter: grant fairness, FIFO limits,
// response steering, backpressure and asynchronous reset.
module tb_lab3_cache_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lab3_cache_mem_arbiter_if c0_if ();
    lab3_cache_mem_arbiter_if c1_if ();
    lab3_cache_mem_arbiter_if mem_if ();

    lab3_cache_mem_arbiter #(.p_num_entries(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .cache0 (c0_if),
        .cache1 (c1_if),
        .mem    (mem_if)
    );

    task automatic idle_inputs();
        c0_if.req_val   = 1'b0;
        c0_if.req_msg   = '0;
        c0_if.resp_rdy  = 1'b0;
        c1_if.req_val   = 1'b0;
        c1_if.req_msg   = '0;
        c1_if.resp_rdy  = 1'b0;
        mem_if.req_rdy  = 1'b0;
        mem_if.resp_val = 1'b0;
        mem_if.resp_msg = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        c0_if.req_val   = 1'b0;
        c1_if.req_val   = 1'b0;
        c0_if.resp_rdy  = 1'b1;
        c1_if.resp_rdy  = 1'b1;
        mem_if.resp_val = 1'b1;
        while (dut.count != 0 && k < 16) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_timeout: count %0d want 0", dut.count);
        end
        mem_if.resp_val = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        c0_if.req_val = 1'b1; c1_if.req_val = 1'b1; mem_if.req_rdy = 1'b1;
        mem_if.resp_val = 1'b1; c0_if.resp_rdy = 1'b1; c1_if.resp_rdy = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if ({mem_if.req_val, c0_if.req_rdy, c1_if.req_rdy, mem_if.resp_rdy,
             c0_if.resp_val, c1_if.resp_val} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000", {mem_if.req_val, c0_if.req_rdy,
                     c1_if.req_rdy, mem_if.resp_rdy, c0_if.resp_val, c1_if.resp_val});
        end
        n_checks++;
        if (dut.count !== 3'd0 || dut.prio !== 1'b0 || dut.wr_ptr !== 2'd0 || dut.rd_ptr !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: count %0d prio %0b wr %0d rd %0d want all 0",
                     dut.count, dut.prio, dut.wr_ptr, dut.rd_ptr);
        end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_solo();
        @(negedge clk);
        c0_if.req_val = 1'b1;
        c0_if.req_msg = '0;
        c0_if.req_msg.addr = 32'h0000_1000;
        c0_if.req_msg.opaque = 8'h05;
        mem_if.req_rdy = 1'b1;
        #1;
        n_checks++;
        if ({mem_if.req_val, c0_if.req_rdy, c1_if.req_rdy} !== 3'b110) begin
            n_fail++;
            $display("FAIL solo_grant: val/rdy0/rdy1 %b want 110", {mem_if.req_val, c0_if.req_rdy, c1_if.req_rdy});
        end
        n_checks++;
        if (mem_if.req_msg.addr !== 32'h0000_1000 || mem_if.req_msg.opaque !== 8'h05 ||
            mem_if.req_msg.msg_type !== 3'd0) begin
            n_fail++;
            $display("FAIL solo_req_msg: addr %h opaque %h type %0d want 00001000 05 0",
                     mem_if.req_msg.addr, mem_if.req_msg.opaque, mem_if.req_msg.msg_type);
        end
        @(negedge clk);
        c0_if.req_val = 1'b0;
        mem_if.resp_val = 1'b1;
        mem_if.resp_msg = '0;
        mem_if.resp_msg.opaque = 8'h05;
        mem_if.resp_msg.data = 32'hCAFE_0000;
        c0_if.resp_rdy = 1'b1; c1_if.resp_rdy = 1'b1;
        #1;
        n_checks++;
        if (dut.count !== 3'd1) begin
            n_fail++;
            $display("FAIL solo_count_push: count %0d want 1", dut.count);
        end
        n_checks++;
        if ({c0_if.resp_val, c1_if.resp_val, mem_if.resp_rdy} !== 3'b101) begin
            n_fail++;
            $display("FAIL solo_resp_route: v0/v1/rdy %b want 101", {c0_if.resp_val, c1_if.resp_val, mem_if.resp_rdy});
        end
        n_checks++;
        if (c0_if.resp_msg.opaque !== 8'h05 || c0_if.resp_msg.data !== 32'hCAFE_0000) begin
            n_fail++;
            $display("FAIL solo_resp_msg: opaque %h data %h want 05 cafe0000",
                     c0_if.resp_msg.opaque, c0_if.resp_msg.data);
        end
        @(negedge clk);
        mem_if.resp_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL solo_count_pop: count %0d want 0", dut.count);
        end
    endtask

    task automatic test_tie();
        logic exp_id;
        apply_reset();
        c0_if.req_msg.opaque = 8'hA0;
        c1_if.req_msg.opaque = 8'hB1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c0_if.req_val = 1'b1; c1_if.req_val = 1'b1; mem_if.req_rdy = 1'b1;
            #1;
            exp_id = (i % 2) == 1;
            n_checks++;
            if ({c0_if.req_rdy, c1_if.req_rdy} !== {!exp_id, exp_id} ||
                mem_if.req_msg.opaque !== (exp_id ? 8'hB1 : 8'hA0)) begin
                n_fail++;
                $display("FAIL tie_grant_%0d: rdy0/rdy1 %b opaque %h want %b %h", i,
                         {c0_if.req_rdy, c1_if.req_rdy}, mem_if.req_msg.opaque,
                         {!exp_id, exp_id}, exp_id ? 8'hB1 : 8'hA0);
            end
        end
        @(negedge clk);
        c0_if.req_val = 1'b0; c1_if.req_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd4) begin
            n_fail++;
            $display("FAIL tie_count_full: count %0d want 4", dut.count);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_if.resp_val = 1'b1; c0_if.resp_rdy = 1'b1; c1_if.resp_rdy = 1'b1;
            #1;
            n_checks++;
            if ({c0_if.resp_val, c1_if.resp_val} !== ((i % 2) == 1 ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL tie_resp_route_%0d: v0/v1 %b want %b", i,
                         {c0_if.resp_val, c1_if.resp_val}, (i % 2) == 1 ? 2'b01 : 2'b10);
            end
        end
        @(negedge clk);
        mem_if.resp_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL tie_count_empty: count %0d want 0", dut.count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            c0_if.req_val = 1'b1; mem_if.req_rdy = 1'b1; mem_if.resp_val = 1'b0;
        end
        @(negedge clk); #1;
        n_checks++;
        if (dut.count !== 3'd4 || {mem_if.req_val, c0_if.req_rdy, c1_if.req_rdy} !== 3'b000) begin
            n_fail++;
            $display("FAIL full_block: count %0d val/rdy0/rdy1 %b want 4 000", dut.count,
                     {mem_if.req_val, c0_if.req_rdy, c1_if.req_rdy});
        end
        @(negedge clk);
        mem_if.resp_val = 1'b1; c0_if.resp_rdy = 1'b1;
        #1;
        n_checks++;
        if ({mem_if.resp_rdy, mem_if.req_val} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_no_bypass: resp_rdy/req_val %b want 10", {mem_if.resp_rdy, mem_if.req_val});
        end
        @(negedge clk);
        mem_if.resp_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd3 || {mem_if.req_val, c0_if.req_rdy} !== 2'b11) begin
            n_fail++;
            $display("FAIL full_regrant: count %0d val/rdy0 %b want 3 11", dut.count, {mem_if.req_val, c0_if.req_rdy});
        end
        @(negedge clk);
        c0_if.req_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_refill: count %0d want 4", dut.count);
        end
        drain();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        c1_if.req_val = 1'b1; mem_if.req_rdy = 1'b1;
        @(negedge clk);
        c1_if.req_val = 1'b0;
        mem_if.resp_val = 1'b1; c1_if.resp_rdy = 1'b0; c0_if.resp_rdy = 1'b1;
        #1;
        n_checks++;
        if (dut.count !== 3'd1 || {mem_if.resp_rdy, c0_if.resp_val, c1_if.resp_val} !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_stall: count %0d rdy/v0/v1 %b want 1 001", dut.count,
                     {mem_if.resp_rdy, c0_if.resp_val, c1_if.resp_val});
        end
        @(negedge clk); #1;
        n_checks++;
        if (dut.count !== 3'd1) begin
            n_fail++;
            $display("FAIL bp_hold: count %0d want 1", dut.count);
        end
        c1_if.resp_rdy = 1'b1;
        #1;
        n_checks++;
        if (mem_if.resp_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: resp_rdy %b want 1", mem_if.resp_rdy);
        end
        @(negedge clk);
        mem_if.resp_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL bp_pop: count %0d want 0", dut.count);
        end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        mem_if.resp_val = 1'b1; c0_if.resp_rdy = 1'b1; c1_if.resp_rdy = 1'b1;
        #1;
        n_checks++;
        if ({mem_if.resp_rdy, c0_if.resp_val, c1_if.resp_val} !== 3'b000) begin
            n_fail++;
            $display("FAIL spurious_resp: rdy/v0/v1 %b want 000", {mem_if.resp_rdy, c0_if.resp_val, c1_if.resp_val});
        end
        @(negedge clk);
        mem_if.resp_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL spurious_count: count %0d want 0", dut.count);
        end
    endtask

    task automatic test_reset_midflight();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c0_if.req_val = 1'b1; mem_if.req_rdy = 1'b1;
        end
        @(negedge clk);
        c0_if.req_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd3 || dut.prio !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: count %0d prio %0b want 3 1", dut.count, dut.prio);
        end
        @(negedge clk);
        c0_if.req_val = 1'b1; c1_if.req_val = 1'b1;
        mem_if.resp_val = 1'b1; c0_if.resp_rdy = 1'b1; c1_if.resp_rdy = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_if.req_val, c0_if.req_rdy, c1_if.req_rdy, mem_if.resp_rdy,
             c0_if.resp_val, c1_if.resp_val} !== 6'b0 || dut.count !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_async_reset: outs %b count %0d want 000000 0", {mem_if.req_val, c0_if.req_rdy,
                     c1_if.req_rdy, mem_if.resp_rdy, c0_if.resp_val, c1_if.resp_val}, dut.count);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_if.resp_val = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 3'd0 || dut.prio !== 1'b0 || {c0_if.req_rdy, c1_if.req_rdy} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_after_release: count %0d prio %0b rdy0/rdy1 %b want 0 0 10",
                     dut.count, dut.prio, {c0_if.req_rdy, c1_if.req_rdy});
        end
        @(negedge clk);
        c0_if.req_val = 1'b0; c1_if.req_val = 1'b0;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_solo();
        test_tie();
        test_full();
        test_backpressure();
        test_spurious();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lab3_cache_mem_arbiter.md
LAB3_CACHE_MEM_ARBITER -- requirements
Module: lab3_cache_mem_arbiter

Interface
REQ-001 Parameter p_num_entries, default 4: depth of the outstanding-request source FIFO; SHALL be a power of two, at least 2.
REQ-002 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Ports cache0_req_val / cache0_req_rdy / cache0_req_msg: input, output, input; widths 1, 1, mem_req_4B_t; icache-side refill/evict request stream.
REQ-005 Ports cache0_resp_val / cache0_resp_rdy / cache0_resp_msg: output, input, output; widths 1, 1, mem_resp_4B_t; icache-side response stream.
REQ-006 Ports cache1_req_val/rdy/msg and cache1_resp_val/rdy/msg SHALL match REQ-004/005 and serve the dcache side.
REQ-007 Ports memreq_val / memreq_rdy / memreq_msg: output, input, output; widths 1, 1, mem_req_4B_t; merged stream to main memory.
REQ-008 Ports memresp_val / memresp_rdy / memresp_msg: input, output, input; widths 1, 1, mem_resp_4B_t; memory responses, returned in request order.

Function
REQ-009 A transfer SHALL occur on any interface only in a cycle where val and rdy are both 1.
REQ-010 The block SHALL keep a 1-bit priority register: 0 means cache0 wins a tie, 1 means cache1 wins.
REQ-011 Grant rule, with fifo_full=(count==p_num_entries): no grant if fifo_full; otherwise grant the only valid requester, or the priority holder if both are valid.
REQ-012 memreq_val SHALL be 1 iff a grant exists.
REQ-013 memreq_msg SHALL equal the granted requester's msg, with all fields unmodified, including opaque.
REQ-014 The granted requester's req_rdy SHALL equal memreq_rdy; the non-granted requester's req_rdy SHALL be 0.
REQ-015 Request path SHALL be combinational, with zero cycles of added latency.
REQ-016 On a memreq fire, the priority register SHALL become the non-granted index; without a fire it SHALL hold.
REQ-017 On a memreq fire, the granted source id (0/1) SHALL be pushed into a circular source FIFO: wr_ptr increments mod p_num_entries, count increments.
REQ-018 When count==0: memresp_rdy=0, both cache resp_val=0, and any memresp_val SHALL be ignored.
REQ-019 When count>0, the head id h SHALL route the response: cacheh_resp_val=memresp_val, cacheh_resp_msg=memresp_msg unmodified, memresp_rdy=cacheh_resp_rdy; the other side's resp_val=0.
REQ-020 The non-selected resp_msg SHALL also be driven with memresp_msg; this is don't-care but deterministic.
REQ-021 On a memresp fire: rd_ptr increments mod p_num_entries, count decrements.
REQ-022 Simultaneous push and pop in one cycle SHALL leave count unchanged and advance both pointers.
REQ-023 Push SHALL be blocked whenever fifo_full, even if a pop occurs the same cycle; no bypass.
REQ-024 Response path SHALL be combinational, with zero cycles of added latency.
REQ-025 count SHALL be $clog2(p_num_entries)+1 bits wide and SHALL never exceed p_num_entries or underflow.

Reset
REQ-026 While reset=1: priority=0, wr_ptr=0, rd_ptr=0, count=0.
REQ-027 While reset=1: memreq_val=0, cache0_req_rdy=0, cache1_req_rdy=0, memresp_rdy=0, cache0_resp_val=0, cache1_resp_val=0.
REQ-028 Reset asserted mid-operation SHALL discard all outstanding source ids; responses still in flight in memory are the system's responsibility.
REQ-029 The first cycle after reset deasserts SHALL behave as an idle arbiter with cache0 priority.

Verification
REQ-030 Solo cache0: read addr 0x1000, opaque 0x05, memreq_rdy=1 -> memreq_msg identical that cycle; memory response returns only on cache0_resp with opaque 0x05; count back to 0.
REQ-031 Tie after reset: both valid every cycle, memreq_rdy=1 -> grants alternate cache0, cache1, cache0, cache1; responses routed to 0, 1, 0, 1 in order.
REQ-032 Full: 4 fires with memresp_val=0 -> count=4 and both req_rdy=0; one response fire -> count=3 and exactly one new grant next cycle.
REQ-033 Response backpressure: head=1, memresp_val=1, cache1_resp_rdy=0 -> memresp_rdy=0 and count unchanged; raise cache1_resp_rdy -> pop that cycle.
REQ-034 Spurious response: count=0, memresp_val=1 -> memresp_rdy=0 and no cache resp_val asserted.
REQ-035 Reset mid-flight: count=3, assert reset asynchronously mid-cycle -> all outputs low immediately; after release count=0 and priority=cache0.
